mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Parametrised multi-cycle multiply/divide unit that owns the HI/LO register pair.
- Replaces the single-cycle MULTU/DIVU path. Adds signed MULT/DIV, a start/busy/done handshake, MTHI/MTLO writes and divide-by-zero handling.
- Sits beside the ALU in the execute stage. The control FSM stalls MFHI/MFLO while busy=1.

Parameters:
- WIDTH, 32, operand width and width of each of HI and LO; must be >=4.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, do not override.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request an operation; sampled only in IDLE
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  input  WIDTH  multiplicand / dividend (rs)
- b  input  WIDTH  multiplier / divisor (rt)
- wr_hi  input  1  MTHI write strobe
- wr_lo  input  1  MTLO write strobe
- wdata  input  WIDTH  MTHI/MTLO data
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse: HI/LO just updated by an operation
- dbz  output  1  qualifies done: the division had a zero divisor
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (async, rst_n=0): state=IDLE, hi=0, lo=0, busy=0, done=0, dbz=0, counter=0. An operation in flight is abandoned and produces no result.
- States:
  - IDLE -> MUL on start with op[1]=0.
  - IDLE -> DIV on start with op[1]=1.
  - MUL/DIV -> FIX after WIDTH iteration cycles.
  - FIX -> IDLE, writing HI/LO.
- Timing, with start sampled at edge E0:
  - Iterations run on edges E1..E_WIDTH.
  - HI/LO are written at edge E_(WIDTH+1).
  - done=1 during the cycle after E_(WIDTH+1).
  - busy=1 from after E0 until E_(WIDTH+1); busy=0 in the done cycle.
  - Total latency is WIDTH+1 edges for every op, including divide by zero.
- Operand capture at E0:
  - Signed ops (MULT, DIV) take magnitudes |a| and |b|; unsigned ops take a and b as-is.
  - Sign flags are latched at E0.
  - a and b may change after E0 without effect.
- MUL: shift-add, one multiplier bit per cycle, into a 2*WIDTH accumulator.
  - FIX negates the 2*WIDTH product if the signs differ (signed only).
  - Result: hi = upper WIDTH bits, lo = lower WIDTH bits.
- DIV: restoring divide, one quotient bit per cycle.
  - FIX negates the quotient if the signs differ, and gives the remainder the dividend's sign (signed only).
  - Result: lo = quotient, hi = remainder. All results are truncated to WIDTH bits.
  - Most-negative / -1 yields lo = most-negative, hi = 0 (wraps; no trap).
- Divide by zero (b==0 at E0, DIV or DIVU):
  - Iterations still run, for fixed latency.
  - Result: lo = all ones, hi = original a (unmodified, signed or not).
  - dbz=1 together with done.
- dbz is 0 whenever done=0.
- start while busy=1 or done=1: ignored; no queueing.
- wr_hi/wr_lo:
  - In IDLE with start=0: hi/lo <= wdata at the next edge. Both strobes may be set together.
  - While busy: dropped.
  - Same cycle as an accepted start: start wins and the write is dropped.
- hi/lo hold their value in every other case. The outputs are the registers themselves, with no combinational path from the inputs.

Optional Feature:
- Macro MDU_FAST_MULT_EN.
- Defined:
  - MULT/MULTU skip the iteration states: IDLE -> FIX -> IDLE.
  - The product is formed with a full WIDTHxWIDTH multiplier on the captured magnitudes.
  - HI/LO are written at E1, with done in the following cycle and busy=1 only between E0 and E1.
  - DIV timing is unchanged.
- Undefined: all ops take WIDTH+1 edges as specified above.

Test Plan:
- MULT a=FFFFFFFD (-3), b=00000005 -> hi=FFFFFFFF, lo=FFFFFFF1. done exactly one cycle, 33 edges after start (or 1 edge with MDU_FAST_MULT_EN).
- MULTU a=FFFFFFFF, b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001. A second start pulsed mid-operation is ignored and the result is unchanged.
- DIV a=FFFFFFF9 (-7), b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF. DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=00000000, dbz=0.
- DIVU a=12345678, b=0 -> lo=FFFFFFFF, hi=12345678, dbz=1 together with done, latency 33 edges.
- wr_hi with wdata=A5A5A5A5 in IDLE -> hi=A5A5A5A5. wr_lo during busy -> lo becomes the operation result only. wr_lo coincident with start -> write dropped.
- Start DIVU, deassert rst_n at iteration 10 -> immediately hi=lo=0, busy=0. After release, no done pulse and the next operation runs correctly.

Source files
------------

// File: rtl/mdu_iter.sv
// mdu_iter: multi-cycle multiply/divide unit owning the HI/LO pair (shift-add multiply, restoring divide).
// Optional macro MDU_FAST_MULT_EN: MULT/MULTU use a full-width multiplier and finish in one edge.
module mdu_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt;
    // Shared work register: MUL = {partial product, multiplier}, DIV = {remainder, quotient}.
    logic [2*WIDTH-1:0] p;
    logic [WIDTH-1:0]   m;
    logic               is_div, neg_res, neg_rem, dz;

    logic               sgn, a_neg, b_neg, accept, last_iter;
    logic [WIDTH-1:0]   a_mag, b_mag, rem_fix, quo_fix;
    logic [WIDTH:0]     mul_sum, div_trial;
    logic [2*WIDTH-1:0] prod_fix;
`ifdef MDU_FAST_MULT_EN
    logic [2*WIDTH-1:0] fast_prod;
`endif

    assign busy = (state != IDLE);

    always_comb begin
        sgn       = ~op[0];
        a_neg     = sgn & a[WIDTH-1];
        b_neg     = sgn & b[WIDTH-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
        accept    = (state == IDLE) && start && !done;
        last_iter = (cnt == CNT_W'(WIDTH - 1));
        mul_sum   = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
        div_trial = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]} - {1'b0, m};
        prod_fix  = neg_res ? -p : p;
        rem_fix   = neg_rem ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
        // A zero divisor leaves |a| in the remainder, so re-signing it restores the original a.
        quo_fix   = dz ? {WIDTH{1'b1}} : (neg_res ? -p[WIDTH-1:0] : p[WIDTH-1:0]);
`ifdef MDU_FAST_MULT_EN
        fast_prod = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
`endif
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef MDU_FAST_MULT_EN
                    state_next = op[1] ? DIV : FIX;
`else
                    state_next = op[1] ? DIV : MUL;
`endif
                end
            end
            MUL:     if (last_iter) state_next = FIX;
            DIV:     if (last_iter) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            p       <= '0;
            m       <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            dz      <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
            dbz     <= 1'b0;
        end else begin
            done <= 1'b0;
            dbz  <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (accept) begin
                        is_div  <= op[1];
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        dz      <= op[1] && (b == '0);
                        if (op[1]) begin
                            p <= {{WIDTH{1'b0}}, a_mag};
                            m <= b_mag;
                        end else begin
`ifdef MDU_FAST_MULT_EN
                            p <= fast_prod;
`else
                            p <= {{WIDTH{1'b0}}, b_mag};
`endif
                            m <= a_mag;
                        end
                    end else begin
                        if (wr_hi) hi <= wdata;
                        if (wr_lo) lo <= wdata;
                    end
                end
                MUL: begin
                    cnt <= cnt + CNT_W'(1);
                    p   <= {mul_sum, p[WIDTH-1:1]};
                end
                DIV: begin
                    cnt <= cnt + CNT_W'(1);
                    // Borrow out of the trial subtract means the divisor did not fit: restore.
                    if (div_trial[WIDTH]) p <= {p[2*WIDTH-2:0], 1'b0};
                    else                  p <= {div_trial[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
                end
                FIX: begin
                    cnt  <= '0;
                    done <= 1'b1;
                    dbz  <= dz;
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed and randomized checks of mdu_iter against a scoreboard of expected {dbz, hi, lo}.
module tb_mdu_iter;
  localparam int W  = 32;
  localparam int XW = 2 * W + 1;
  localparam int DIV_LAT = W + 1;
`ifdef MDU_FAST_MULT_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W + 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n, start, wr_hi, wr_lo;
  logic [1:0]   op;
  logic [W-1:0] a, b, wdata;
  logic         busy, done, dbz;
  logic [W-1:0] hi, lo;

  logic [XW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  mdu_iter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
    .busy(busy), .done(done), .dbz(dbz), .hi(hi), .lo(lo)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [XW-1:0] obs, input logic [XW-1:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference model: {dbz, hi, lo} from plain 64-bit arithmetic.
  function automatic logic [XW-1:0] model(input logic [1:0] mop, input logic [W-1:0] ma, input logic [W-1:0] mb);
    longint sa, sb, q, r;
    logic [2*W-1:0] prod;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    case (mop)
      2'b00: begin
        prod = 64'(sa * sb);
        return {1'b0, prod};
      end
      2'b01: begin
        prod = {32'b0, ma} * {32'b0, mb};
        return {1'b0, prod};
      end
      default: begin
        if (mb == '0) return {1'b1, ma, {W{1'b1}}};
        if (mop == 2'b10) begin
          q = sa / sb;
          r = sa % sb;
          return {1'b0, r[W-1:0], q[W-1:0]};
        end
        return {1'b0, ma % mb, ma / mb};
      end
    endcase
  endfunction

  // driver: pulse start for one edge (E0); optionally assert wr_lo in the same cycle
  task automatic start_op(input logic [1:0] o, input logic [W-1:0] oa, input logic [W-1:0] ob,
                          input logic [XW-1:0] expv, input bit with_wr);
    logic [W-1:0] lo_before;
    lo_before = lo;
    start = 1'b1; op = o; a = oa; b = ob;
    if (with_wr) begin
      wr_lo = 1'b1;
      wdata = ~lo_before;
    end
    exp_q.push_back(expv);
    @(posedge clk); #1;
    start = 1'b0; wr_lo = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
    check("busy_after_start", XW'(busy), XW'(1'b1));
    if (with_wr) check("wr_lo_with_start_dropped", XW'(lo), XW'(lo_before));
  endtask

  // inj: 0 none, 1 extra start pulse mid-op, 2 wr_lo pulse mid-op
  task automatic wait_done(input string tag, input int exp_lat, input int inj);
    int k;
    bit seen;
    logic [W-1:0] lo_save;
    logic [XW-1:0] expv;
    k = 0; seen = 1'b0; lo_save = lo;
    while (!seen && k < 100) begin
      @(posedge clk); #1;
      k++;
      if (k == 6) begin start = 1'b0; wr_lo = 1'b0; end
      if (k == 5 && inj == 1) begin start = 1'b1; op = 2'b10; a = 32'h1; b = 32'h1; end
      if (k == 5 && inj == 2) begin lo_save = lo; wr_lo = 1'b1; wdata = 32'hDEADBEEF; end
      if (k == 7 && inj == 2) check({tag, "_lo_hold_busy"}, XW'(lo), XW'(lo_save));
      if (k == 3 && exp_lat > 3) check({tag, "_busy_mid"}, XW'(busy), XW'(1'b1));
      if (done) seen = 1'b1;
    end
    check({tag, "_latency"}, XW'(k), XW'(exp_lat));
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, XW'(1'b1), XW'(1'b0));
    end else begin
      expv = exp_q.pop_front();
      check({tag, "_result"}, {dbz, hi, lo}, expv);
    end
    check({tag, "_busy_in_done"}, XW'(busy), XW'(1'b0));
    @(posedge clk); #1;
    check({tag, "_done_one_cycle"}, XW'({busy, done, dbz}), XW'(3'b000));
  endtask

  initial begin
    int dones;
    logic [1:0] ro;
    logic [W-1:0] ra, rb;
    rst_n = 1'b0; start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    op = 2'b00; a = '0; b = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {hi, lo, busy}, '0);
    check("reset_flags", XW'({done, dbz}), XW'(2'b00));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // MTHI / MTLO in IDLE
    wr_hi = 1'b1; wdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    wr_hi = 1'b0;
    check("mthi", XW'(hi), XW'(32'hA5A5A5A5));
    wr_lo = 1'b1; wdata = 32'h5A5A5A5A;
    @(posedge clk); #1;
    wr_lo = 1'b0;
    check("mtlo", XW'({hi, lo}), XW'({32'hA5A5A5A5, 32'h5A5A5A5A}));

    // MULT -3 * 5
    start_op(2'b00, 32'hFFFFFFFD, 32'h00000005, {1'b0, 32'hFFFFFFFF, 32'hFFFFFFF1}, 1'b0);
    wait_done("mult_neg", MUL_LAT, 0);

    // MULTU max*max with a spurious start mid-operation
    start_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, {1'b0, 32'hFFFFFFFE, 32'h00000001}, 1'b0);
    wait_done("multu_max", MUL_LAT, 1);
    start = 1'b0;

    // signed divides
    start_op(2'b10, 32'hFFFFFFF9, 32'h00000002, {1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0);
    wait_done("div_neg", DIV_LAT, 0);
    start_op(2'b10, 32'h80000000, 32'hFFFFFFFF, {1'b0, 32'h00000000, 32'h80000000}, 1'b0);
    wait_done("div_ovf", DIV_LAT, 0);

    // divide by zero, unsigned and signed
    start_op(2'b11, 32'h12345678, 32'h0, {1'b1, 32'h12345678, 32'hFFFFFFFF}, 1'b0);
    wait_done("divu_zero", DIV_LAT, 0);
    start_op(2'b10, 32'h80000005, 32'h0, {1'b1, 32'h80000005, 32'hFFFFFFFF}, 1'b0);
    wait_done("div_zero_neg", DIV_LAT, 0);

    // wr_lo during busy is dropped; wr_lo with start is dropped
    start_op(2'b11, 32'd100, 32'd7, {1'b0, 32'd2, 32'd14}, 1'b0);
    wait_done("divu_wr_busy", DIV_LAT, 2);
    wr_lo = 1'b0;
    start_op(2'b01, 32'd7, 32'd6, {1'b0, 32'd0, 32'd42}, 1'b1);
    wait_done("multu_wr_start", MUL_LAT, 0);

    // randomized operations against the model
    for (int i = 0; i < 6; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 3) ? '0 : $urandom;
      start_op(ro, ra, rb, model(ro, ra, rb), 1'b0);
      wait_done($sformatf("rand%0d_op%0d", i, ro), ro[1] ? DIV_LAT : MUL_LAT, 0);
    end

    // reset in the middle of a divide
    start_op(2'b11, 32'hCAFEF00D, 32'h00000123, model(2'b11, 32'hCAFEF00D, 32'h00000123), 1'b0);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midop_reset_regs", {hi, lo, busy}, '0);
    check("midop_reset_flags", XW'({done, dbz}), XW'(2'b00));
    void'(exp_q.pop_back());
    @(posedge clk); #1;
    rst_n = 1'b1;
    dones = 0;
    repeat (W + 5) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    check("no_done_after_reset", XW'(dones), XW'(0));
    start_op(2'b10, 32'hFFFFFF00, 32'h00000011, model(2'b10, 32'hFFFFFF00, 32'h00000011), 1'b0);
    wait_done("after_reset", DIV_LAT, 0);

    check("scoreboard_drained", XW'(exp_q.size()), XW'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
